aes_round_ctrl: RTL and testbench

- Sequencer for the iterative AES datapath. It issues the per-step enables for SubBytes, ShiftRows, MixColumns and AddRoundKey, and their inverse forms in decrypt mode.
- It tracks the round number, drives the round-key index to the key-schedule storage, and selects between the fresh input block and the feedback state.
- It sits between the top-level block interface (start/busy/done) and the step units. Each step unit holds its done high one cycle after it samples enable high, and keeps it high while enable stays high.

---
 rtl/aes_ctrl_pkg.sv | 30 +++
 rtl/aes_round_counter.sv | 56 +++++
 rtl/aes_round_ctrl.sv | 162 ++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_ctrl_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;
    localparam int unsigned STEP_N    = 4;

    // ST_NEXT is never occupied; its decision is folded into the WAIT exit.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_NEXT = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STEP_SB  = 2'd0,
        STEP_SR  = 2'd1,
        STEP_MC  = 2'd2,
        STEP_ARK = 2'd3
    } step_t;

    // Enable vector bit order: {ark, mc, sr, sb}.
    function automatic logic [STEP_N-1:0] step_onehot(input step_t s);
        return STEP_N'(1) << s;
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round counter with clear/increment, first/last flags and the round-key index
// mapping (encrypt: key = round, decrypt: key = NR - round).
module aes_round_counter
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [RW-1:0] o_round_idx,
    output logic [RW-1:0] o_key_idx,
    output logic          o_first_c,
    output logic          o_last_c
);

    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
        $error("aes_round_counter: NR must be 10, 12 or 14");
    end
    if (NR >= (2 ** RW)) begin : g_bad_rw
        $error("aes_round_counter: RW too narrow for NR");
    end

    logic [RW-1:0] r_round;
    logic [RW-1:0] r_key;
    logic [RW-1:0] w_round_nxt;

    // Saturates at NR so the key index can never wrap.
    always_comb begin
        w_round_nxt = r_round;
        if (i_clr) begin
            w_round_nxt = '0;
        end else if (i_inc && (r_round != RW'(NR))) begin
            w_round_nxt = r_round + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= '0;
            r_key   <= '0;
        end else begin
            r_round <= w_round_nxt;
            r_key   <= i_dec ? (RW'(NR) - w_round_nxt) : w_round_nxt;
        end
    end

    assign o_round_idx = r_round;
    assign o_key_idx   = r_key;
    assign o_first_c   = (r_round == '0);
    assign o_last_c    = (r_round == RW'(NR));

endmodule

// File: rtl/aes_round_ctrl.sv
// Step sequencer for the iterative AES datapath: issues SB/SR/MC/ARK enables
// (forward or inverse order), tracks the round and drives the key index.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_decrypt,
    input  logic          i_sb_done,
    input  logic          i_sr_done,
    input  logic          i_mc_done,
    input  logic          i_ark_done,
    output logic          o_sb_en,
    output logic          o_sr_en,
    output logic          o_mc_en,
    output logic          o_ark_en,
    output logic          o_inv,
    output logic          o_in_sel,
    output logic [RW-1:0] o_key_idx,
    output logic [RW-1:0] o_round_idx,
    output logic          o_busy,
    output logic          o_done
);

    state_t              r_state;
    state_t              w_state_nxt;
    step_t               r_step;
    step_t               w_step_nxt;
    logic                r_inv;
    logic                w_inv_nxt;
    logic                r_in_sel;
    logic                w_in_sel_nxt;
    logic [STEP_N-1:0]   r_en;
    logic [STEP_N-1:0]   w_en_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_clr;
    logic                w_inc;
    logic                w_sel_done;
    logic                w_first_c;
    logic                w_last_c;

    aes_round_counter #(
        .NR (NR),
        .RW (RW)
    ) u_round_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_inc       (w_inc),
        .i_dec       (w_inv_nxt),
        .o_round_idx (o_round_idx),
        .o_key_idx   (o_key_idx),
        .o_first_c   (w_first_c),
        .o_last_c    (w_last_c)
    );

    always_comb begin
        w_sel_done = 1'b0;
        case (r_step)
            STEP_SB:  w_sel_done = i_sb_done;
            STEP_SR:  w_sel_done = i_sr_done;
            STEP_MC:  w_sel_done = i_mc_done;
            STEP_ARK: w_sel_done = i_ark_done;
            default:  w_sel_done = 1'b0;
        endcase
    end

    // Next state, next step and the values of every registered output.
    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_inv_nxt    = r_inv;
        w_in_sel_nxt = r_in_sel;
        w_clr        = 1'b0;
        w_inc        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt  = ST_ARM;
                    w_step_nxt   = STEP_ARK;
                    w_inv_nxt    = i_decrypt;
                    w_in_sel_nxt = 1'b1;
                    w_clr        = 1'b1;
                end
            end
            // Done is ignored here so a stale done cannot complete the step.
            ST_ARM: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_sel_done) begin
                    w_state_nxt  = ST_ARM;
                    w_in_sel_nxt = 1'b0;
                    case (r_step)
                        STEP_ARK: begin
                            if (w_last_c) begin
                                w_state_nxt = ST_FIN;
                            end else begin
                                w_inc      = 1'b1;
                                w_step_nxt = !r_inv ? STEP_SB :
                                             (w_first_c ? STEP_SR : STEP_MC);
                            end
                        end
                        STEP_SB: w_step_nxt = r_inv ? STEP_ARK : STEP_SR;
                        STEP_SR: w_step_nxt = r_inv ? STEP_SB :
                                              (w_last_c ? STEP_ARK : STEP_MC);
                        STEP_MC: w_step_nxt = r_inv ? STEP_SR : STEP_ARK;
                        default: w_step_nxt = STEP_ARK;
                    endcase
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_WAIT);
        w_done_nxt = (w_state_nxt == ST_FIN);
        w_en_nxt   = w_busy_nxt ? step_onehot(w_step_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_step   <= STEP_SB;
            r_inv    <= 1'b0;
            r_in_sel <= 1'b0;
            r_en     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_inv    <= w_inv_nxt;
            r_in_sel <= w_in_sel_nxt;
            r_en     <= w_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_sb_en  = r_en[STEP_SB];
    assign o_sr_en  = r_en[STEP_SR];
    assign o_mc_en  = r_en[STEP_MC];
    assign o_ark_en = r_en[STEP_ARK];
    assign o_inv    = r_inv;
    assign o_in_sel = r_in_sel;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl (NR=10) with latency-programmable stub step units.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;
    localparam int C_SB = 0;
    localparam int C_SR = 1;
    localparam int C_MC = 2;
    localparam int C_ARK = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          decrypt = 1'b0;
    logic          sb_done, sr_done, mc_done, ark_done;
    logic          sb_en, sr_en, mc_en, ark_en;
    logic          inv, in_sel, busy, done;
    logic [RW-1:0] key_idx, round_idx;

    int n_tests = 0;
    int n_fail  = 0;

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_decrypt   (decrypt),
        .i_sb_done   (sb_done),
        .i_sr_done   (sr_done),
        .i_mc_done   (mc_done),
        .i_ark_done  (ark_done),
        .o_sb_en     (sb_en),
        .o_sr_en     (sr_en),
        .o_mc_en     (mc_en),
        .o_ark_en    (ark_en),
        .o_inv       (inv),
        .o_in_sel    (in_sel),
        .o_key_idx   (key_idx),
        .o_round_idx (round_idx),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Stub units: done rises lat[u] cycles after enable is first sampled.
    logic [3:0] en_v;
    int         cnt [4];
    int         lat [4];
    logic       stale_ark = 1'b0;

    assign en_v = {ark_en, mc_en, sr_en, sb_en};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 4; u++) cnt[u] <= 0;
        end else begin
            for (int u = 0; u < 4; u++) begin
                if (!en_v[u])             cnt[u] <= 0;
                else if (cnt[u] < lat[u]) cnt[u] <= cnt[u] + 1;
            end
        end
    end

    assign sb_done  = en_v[0] && (cnt[0] >= lat[0]);
    assign sr_done  = en_v[1] && (cnt[1] >= lat[1]);
    assign mc_done  = en_v[2] && (cnt[2] >= lat[2]);
    assign ark_done = stale_ark || (en_v[3] && (cnt[3] >= lat[3]));

    int exp_code [64];
    int exp_key  [64];
    int n_exp;

    function automatic void push(input int code, input int key);
        exp_code[n_exp] = code;
        exp_key[n_exp]  = key;
        n_exp++;
    endfunction

    function automatic void build_exp(input bit dec);
        n_exp = 0;
        if (!dec) begin
            push(C_ARK, 0);
            for (int r = 1; r <= NR - 1; r++) begin
                push(C_SB, 0); push(C_SR, 0); push(C_MC, 0); push(C_ARK, r);
            end
            push(C_SB, 0); push(C_SR, 0); push(C_ARK, NR);
        end else begin
            push(C_ARK, NR);
            for (int r = NR - 1; r >= 1; r--) begin
                push(C_SR, 0); push(C_SB, 0); push(C_ARK, r); push(C_MC, 0);
            end
            push(C_SR, 0); push(C_SB, 0); push(C_ARK, 0);
        end
    endfunction

    function automatic int exp_dur(input int code);
        return (code == C_MC) ? (1 + lat[C_MC]) : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pulse_start(input bit dec);
        @(negedge clk);
        start   = 1'b1;
        decrypt = dec;
        @(negedge clk);
        start   = 1'b0;
        decrypt = !dec;
    endtask

    // Runs one block from a start pulse; poke re-pulses start at cycle 20 and in the done cycle.
    task automatic run_block(input string tag, input bit dec, input int exp_done, input bit poke);
        int n_steps = 0, n_seq_bad = 0, n_key_bad = 0, n_dur_bad = 0;
        int n_hot_bad = 0, n_inv_bad = 0, n_insel = 0, n_done = 0;
        int done_cyc = -1, start_c = 0, prev_code = -1, code;
        logic [3:0] prev_en = '0;
        logic [3:0] en;
        build_exp(dec);
        pulse_start(dec);
        for (int c = 1; c <= exp_done + 90; c++) begin
            en = en_v;
            if (c == 1) begin
                chk($sformatf("%s.busy_c1", tag), 32'(busy), 32'd1);
                chk($sformatf("%s.in_sel_c1", tag), 32'(in_sel), 32'd1);
            end
            start = poke && (c == 20 || c == exp_done);
            if ($countones(en) > 1) n_hot_bad++;
            if (busy && inv !== dec) n_inv_bad++;
            if (in_sel) n_insel++;
            if (en != '0 && en != prev_en) begin
                if (prev_code >= 0 && (c - start_c) != exp_dur(prev_code)) n_dur_bad++;
                case (en)
                    4'b0001: code = C_SB;
                    4'b0010: code = C_SR;
                    4'b0100: code = C_MC;
                    4'b1000: code = C_ARK;
                    default: code = -1;
                endcase
                if (n_steps < n_exp && code != exp_code[n_steps]) n_seq_bad++;
                n_steps++;
                start_c   = c;
                prev_code = code;
            end
            if (en[3] && n_steps >= 1 && n_steps <= n_exp) begin
                if (int'(key_idx) != exp_key[n_steps-1]) n_key_bad++;
                if (int'(round_idx) != (dec ? NR - exp_key[n_steps-1] : exp_key[n_steps-1]))
                    n_key_bad++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    if (busy) n_inv_bad++;
                    if (prev_code >= 0 && (c - start_c) != exp_dur(prev_code)) n_dur_bad++;
                end
            end
            prev_en = en;
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("%s.steps", tag), 32'(n_steps), 32'd40);
        chk($sformatf("%s.order_errs", tag), 32'(n_seq_bad), 32'd0);
        chk($sformatf("%s.key_round_errs", tag), 32'(n_key_bad), 32'd0);
        chk($sformatf("%s.step_len_errs", tag), 32'(n_dur_bad), 32'd0);
        chk($sformatf("%s.multi_en", tag), 32'(n_hot_bad), 32'd0);
        chk($sformatf("%s.inv_busy_errs", tag), 32'(n_inv_bad), 32'd0);
        chk($sformatf("%s.in_sel_cycles", tag), 32'(n_insel), 32'd2);
        chk($sformatf("%s.done_count", tag), 32'(n_done), 32'd1);
        chk($sformatf("%s.done_cycle", tag), 32'(done_cyc), 32'(exp_done));
        chk($sformatf("%s.end_round", tag), 32'(round_idx), 32'(NR));
        chk($sformatf("%s.end_busy", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done_after;
        for (int u = 0; u < 4; u++) lat[u] = 1;

        // Reset state
        @(negedge clk);
        chk("reset.outputs", 32'({sb_en, sr_en, mc_en, ark_en, inv, in_sel, key_idx,
                                  round_idx, busy, done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", 32'(busy), 32'd0);

        run_block("enc", 1'b0, 81, 1'b0);
        run_block("dec", 1'b1, 81, 1'b0);

        stale_ark = 1'b1;
        run_block("stale_ark", 1'b0, 81, 1'b0);
        stale_ark = 1'b0;

        lat[C_MC] = 5;
        run_block("slow_mc", 1'b0, 81 + 36, 1'b0);
        lat[C_MC] = 1;

        run_block("start_poke", 1'b0, 81, 1'b1);

        // Asynchronous abort mid-block at cycle 37
        pulse_start(1'b0);
        repeat (36) @(negedge clk);
        chk("abort.busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort.outputs", 32'({sb_en, sr_en, mc_en, ark_en, inv, in_sel, key_idx,
                                  round_idx, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_done_after = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) n_done_after++;
            @(negedge clk);
        end
        chk("abort.no_done", 32'(n_done_after), 32'd0);

        run_block("post_rst_dec", 1'b1, 81, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
